// File: rtl/slow_access_ctl_pkg.sv
// -----------------------------------------------------------------------------
// slow_access_ctl_pkg
// Shared definitions for the slow-access controller and the settings register
// that feeds it.
//   slowState_e       : controller state encoding (ST_IDLE/ST_ACCESS/ST_HOLD)
//   TICK_DIV_DEFAULT  : default number of CLK cycles per timeout tick
//   SLOW_TIMEOUT_RST  : value the SlowTimeout field takes out of reset, kept
//                       here so the settings register and this block agree
//   anySlowHit()      : OR over the per-device (select && enable) pairs
// -----------------------------------------------------------------------------
package slow_access_ctl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_HOLD   = 2'd2
  } slowState_e;

  localparam int         TICK_DIV_DEFAULT = 16;
  localparam logic [3:0] SLOW_TIMEOUT_RST = 4'h3;

  // A device counts as a slow hit only when it is both selected by address
  // decode and enabled as slow in the settings register.
  function automatic logic anySlowHit(input logic [5:0] cs, input logic [5:0] en);
    return |(cs & en);
  endfunction

endpackage

// File: rtl/slow_access_ctl_tick.sv
// -----------------------------------------------------------------------------
// slow_tick_prescaler
// Free-running prescaler that produces one tick every TICK_DIV cycles. The
// controller holds it in clear outside the hold window so every hold period
// starts from a fresh count.
// Ports:
//   clk_i   : system clock (rising edge)
//   rst_i   : synchronous active-high reset
//   clear_i : forces the count to zero on the next edge and masks the tick
//   tick_o  : high during the cycle in which the count sits at TICK_DIV-1
// Parameters:
//   TICK_DIV : cycles per tick, legal range 2..256
// -----------------------------------------------------------------------------
module slow_tick_prescaler #(
  parameter int TICK_DIV = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] WrapVal = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] count_q;
  logic [CntW-1:0] count_d;

  // Next count: clear wins, otherwise step and wrap at TICK_DIV-1 so that
  // non-power-of-two dividers still give an exact period.
  always_comb begin
    count_d = count_q + CntW'(1);
    if (clear_i) begin
      count_d = '0;
    end else if (count_q == WrapVal) begin
      count_d = '0;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The wrap cycle is the tick; a cleared prescaler never ticks.
  assign tick_o = !clear_i && (count_q == WrapVal);

endmodule

// File: rtl/slow_access_ctl.sv
// -----------------------------------------------------------------------------
// slow_access_ctl
// Decides when the accelerated bus must drop to stock speed. Slow is raised
// for the whole of any access to an enabled slow device and then held for
// SlowTimeout ticks so back-to-back peripheral accesses stay slow.
// Ports:
//   CLK            : system clock, all logic on the rising edge
//   POR            : synchronous active-high reset
//   BACT           : bus cycle active, high for the whole 68k access
//   IACKCS..SndCS  : device selects from address decode
//   SlowIACK..SlowSnd : per-device slow enables
//   SlowClockGate  : clock-gate request bit from the settings register
//   SlowTimeout    : hold time in ticks after a slow access ends
//   Slow           : registered, run the bus at stock speed
//   SlowHit        : one-cycle pulse marking the start of a slow access
//   ClockGate      : registered clock-gate request
// Configuration:
//   SLOW_CLKGATE_EN : when defined, ClockGate follows Slow gated by
//                     SlowClockGate; when undefined ClockGate is tied low.
// -----------------------------------------------------------------------------
module slow_access_ctl
  import slow_access_ctl_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic       CLK,
  input  logic       POR,
  input  logic       BACT,
  input  logic       IACKCS,
  input  logic       VIACS,
  input  logic       IWMCS,
  input  logic       SCCCS,
  input  logic       SCSICS,
  input  logic       SndCS,
  input  logic       SlowIACK,
  input  logic       SlowVIA,
  input  logic       SlowIWM,
  input  logic       SlowSCC,
  input  logic       SlowSCSI,
  input  logic       SlowSnd,
  input  logic       SlowClockGate,
  input  logic [3:0] SlowTimeout,
  output logic       Slow,
  output logic       SlowHit,
  output logic       ClockGate
);

  slowState_e state_q;
  slowState_e state_d;
  logic       bactR_q;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic       slow_q;
  logic       slowHit_q;
  logic       hitPulse;
  logic       start;
  logic       hit;
  logic       tick;
  logic       prescClear;

  assign start = BACT && !bactR_q;
  assign hit   = anySlowHit({SndCS, SCSICS, SCCCS, IWMCS, VIACS, IACKCS},
                            {SlowSnd, SlowSCSI, SlowSCC, SlowIWM, SlowVIA, SlowIACK});

  // The prescaler only runs while we sit in HOLD. Holding it clear in every
  // other state means the ACCESS->HOLD edge leaves it at zero, so HOLD lasts
  // exactly SlowTimeout*TICK_DIV cycles.
  assign prescClear = (state_q != ST_HOLD);

  slow_tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) uTick (
    .clk_i   (CLK),
    .rst_i   (POR),
    .clear_i (prescClear),
    .tick_o  (tick)
  );

  // Next-state logic. A qualifying Start in HOLD is checked before the tick
  // so that a new slow access landing on the final tick re-enters ACCESS and
  // Slow never drops. SlowTimeout is only sampled on the ACCESS->HOLD edge,
  // and cnt is never decremented below zero because HOLD exits at cnt==1.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hitPulse = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && hit) begin
          state_d  = ST_ACCESS;
          hitPulse = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (!BACT) begin
          if (SlowTimeout == 4'd0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLD;
            cnt_d   = SlowTimeout;
          end
        end
      end
      ST_HOLD: begin
        if (start && hit) begin
          state_d  = ST_ACCESS;
          hitPulse = 1'b1;
        end else if (tick) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers. Slow is registered from the next state so it
  // rises one edge after the Start cycle and falls on the same edge the FSM
  // returns to IDLE. Reset overrides everything, including mid-access.
  always_ff @(posedge CLK) begin
    if (POR) begin
      state_q   <= ST_IDLE;
      bactR_q   <= 1'b0;
      cnt_q     <= 4'd0;
      slow_q    <= 1'b0;
      slowHit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bactR_q   <= BACT;
      cnt_q     <= cnt_d;
      slow_q    <= (state_d != ST_IDLE);
      slowHit_q <= hitPulse;
    end
  end

  assign Slow    = slow_q;
  assign SlowHit = slowHit_q;

`ifdef SLOW_CLKGATE_EN
  logic clockGate_q;

  // Clock-gate request shares Slow's timing and is forced low whenever the
  // bus is not being held slow.
  always_ff @(posedge CLK) begin
    if (POR) begin
      clockGate_q <= 1'b0;
    end else begin
      clockGate_q <= SlowClockGate && (state_d != ST_IDLE);
    end
  end

  assign ClockGate = clockGate_q;
`else
  logic unusedGate;

  // Feature compiled out: the request bit is accepted but has no effect.
  assign unusedGate = SlowClockGate;
  assign ClockGate  = 1'b0;
`endif

endmodule

// File: tb/tb_slow_access_ctl.sv
// -----------------------------------------------------------------------------
// tb_slow_access_ctl
// Self-checking bench for slow_access_ctl. A behavioural model tracks the slow
// window as "in an access" plus a remaining hold length in plain cycles
// (SlowTimeout*TICK_DIV), and every cycle's Slow/SlowHit/ClockGate is compared
// against it. Directed scenarios add explicit cycle counts for reset, timeout
// length, zero timeout, disabled devices and back-to-back accesses, followed
// by a randomized run.
// -----------------------------------------------------------------------------
module tb_slow_access_ctl;
  import slow_access_ctl_pkg::*;

  localparam int TD = 16;

`ifdef SLOW_CLKGATE_EN
  localparam bit GATE_ON = 1'b1;
`else
  localparam bit GATE_ON = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       POR = 1'b1;
  logic       BACT = 1'b0;
  logic [5:0] csVec = 6'd0;
  logic [5:0] enVec = 6'd0;
  logic       SlowClockGate = 1'b0;
  logic [3:0] SlowTimeout = 4'd0;
  logic       Slow;
  logic       SlowHit;
  logic       ClockGate;

  int checkCount = 0;
  int failCount  = 0;
  int slowCount  = 0;
  int hitCount   = 0;

  bit mPrevBact = 1'b0;
  bit mBusy     = 1'b0;
  int mHoldLeft = 0;
  bit expSlow   = 1'b0;
  bit expHit    = 1'b0;
  bit expGate   = 1'b0;

  localparam logic [5:0] DEV_VIA  = 6'b000010;
  localparam logic [5:0] DEV_IWM  = 6'b000100;
  localparam logic [5:0] DEV_SCC  = 6'b001000;
  localparam logic [5:0] DEV_SCSI = 6'b010000;
  localparam logic [5:0] EN_ALL   = 6'b111111;

  slow_access_ctl #(
    .TICK_DIV (TD)
  ) dut (
    .CLK           (CLK),
    .POR           (POR),
    .BACT          (BACT),
    .IACKCS        (csVec[0]),
    .VIACS         (csVec[1]),
    .IWMCS         (csVec[2]),
    .SCCCS         (csVec[3]),
    .SCSICS        (csVec[4]),
    .SndCS         (csVec[5]),
    .SlowIACK      (enVec[0]),
    .SlowVIA       (enVec[1]),
    .SlowIWM       (enVec[2]),
    .SlowSCC       (enVec[3]),
    .SlowSCSI      (enVec[4]),
    .SlowSnd       (enVec[5]),
    .SlowClockGate (SlowClockGate),
    .SlowTimeout   (SlowTimeout),
    .Slow          (Slow),
    .SlowHit       (SlowHit),
    .ClockGate     (ClockGate)
  );

  always #5 CLK = ~CLK;

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference model for one rising edge: a slow window is either an open
  // access or a countdown of remaining hold cycles. A qualifying Start always
  // reopens the access, even on the very last hold cycle.
  task automatic modelEdge(input logic por, input logic bact, input logic [5:0] cs,
                           input logic [5:0] en, input logic [3:0] tmo, input logic gate);
    bit startNow;
    bit hitNow;
    if (por) begin
      mPrevBact = 1'b0;
      mBusy     = 1'b0;
      mHoldLeft = 0;
      expSlow   = 1'b0;
      expHit    = 1'b0;
      expGate   = 1'b0;
    end else begin
      startNow = bact && !mPrevBact;
      hitNow   = |(cs & en);
      expHit   = 1'b0;
      if (startNow && hitNow) begin
        mBusy     = 1'b1;
        mHoldLeft = 0;
        expHit    = 1'b1;
      end else if (mBusy) begin
        if (!bact) begin
          mBusy     = 1'b0;
          mHoldLeft = int'(tmo) * TD;
        end
      end else if (mHoldLeft > 0) begin
        mHoldLeft--;
      end
      expSlow   = mBusy || (mHoldLeft > 0);
      expGate   = GATE_ON && gate && expSlow;
      mPrevBact = bact;
    end
  endtask

  // Drive one cycle of inputs just after a falling edge, advance the model,
  // then compare all outputs at the next falling edge.
  task automatic applyStimulus(input logic por, input logic bact, input logic [5:0] cs,
                               input logic [5:0] en, input logic [3:0] tmo, input logic gate);
    POR           = por;
    BACT          = bact;
    csVec         = cs;
    enVec         = en;
    SlowTimeout   = tmo;
    SlowClockGate = gate;
    modelEdge(por, bact, cs, en, tmo, gate);
    @(negedge CLK);
    checkOutput("Slow", Slow, expSlow);
    checkOutput("SlowHit", SlowHit, expHit);
    checkOutput("ClockGate", ClockGate, expGate);
    slowCount += int'(Slow === 1'b1);
    hitCount  += int'(SlowHit === 1'b1);
  endtask

  initial begin
    int         busLeft;
    int         gapLeft;
    logic [5:0] curCs;
    logic [5:0] curEn;
    logic [3:0] curTmo;
    logic       curGate;

    @(negedge CLK);

    $display("[TB] reset during HOLD");
    applyStimulus(1'b1, 1'b0, 6'd0, EN_ALL, 4'd3, 1'b1);
    checkOutput("rst_init_slow", Slow, 0);
    applyStimulus(1'b0, 1'b1, DEV_VIA, EN_ALL, 4'd3, 1'b1);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, 6'd0, EN_ALL, 4'd3, 1'b1);
    end
    checkOutput("rst_hold_slow", Slow, 1);
    applyStimulus(1'b1, 1'b0, 6'd0, EN_ALL, 4'd3, 1'b1);
    checkOutput("rst_slow_low", Slow, 0);
    checkOutput("rst_gate_low", ClockGate, 0);
    applyStimulus(1'b0, 1'b1, DEV_VIA, EN_ALL, 4'd3, 1'b1);
    checkOutput("rst_first_hit", SlowHit, 1);

    $display("[TB] timeout length");
    applyStimulus(1'b1, 1'b0, 6'd0, EN_ALL, 4'd3, 1'b1);
    slowCount = 0;
    hitCount  = 0;
    for (int i = 0; i < 65; i++) begin
      applyStimulus(1'b0, (i < 5), (i < 5) ? DEV_VIA : 6'd0, EN_ALL, 4'd3, 1'b1);
    end
    checkOutput("tmo_slow_cycles", slowCount, 5 + 3 * TD);
    checkOutput("tmo_hit_cycles", hitCount, 1);

    $display("[TB] zero timeout");
    applyStimulus(1'b1, 1'b0, 6'd0, EN_ALL, 4'd0, 1'b1);
    slowCount = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, DEV_SCC, EN_ALL, 4'd0, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 6'd0, EN_ALL, 4'd0, 1'b1);
    checkOutput("zero_fall", Slow, 0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 6'd0, EN_ALL, 4'd0, 1'b1);
    end
    checkOutput("zero_slow_cycles", slowCount, 4);

    $display("[TB] disabled device");
    applyStimulus(1'b1, 1'b0, 6'd0, EN_ALL, 4'd3, 1'b1);
    slowCount = 0;
    hitCount  = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0, (i < 6), DEV_SCSI, 6'b101111, 4'd3, 1'b1);
    end
    checkOutput("dis_slow_cycles", slowCount, 0);
    checkOutput("dis_hit_cycles", hitCount, 0);

    $display("[TB] back-to-back on final tick");
    applyStimulus(1'b1, 1'b0, 6'd0, EN_ALL, 4'd1, 1'b1);
    slowCount = 0;
    hitCount  = 0;
    for (int i = 0; i < 46; i++) begin
      applyStimulus(1'b0, (i < 2) || (i == 18) || (i == 19),
                    DEV_IWM, EN_ALL, 4'd1, 1'b1);
      if (i == 18) begin
        checkOutput("b2b_no_gap", Slow, 1);
        checkOutput("b2b_second_hit", SlowHit, 1);
      end
    end
    checkOutput("b2b_slow_cycles", slowCount, 2 + TD + 2 + TD);
    checkOutput("b2b_hit_cycles", hitCount, 2);

    $display("[TB] randomized traffic");
    busLeft = 0;
    gapLeft = 0;
    curCs   = DEV_VIA;
    curEn   = EN_ALL;
    curTmo  = SLOW_TIMEOUT_RST;
    curGate = 1'b1;
    for (int c = 0; c < 2500; c++) begin
      logic b;
      logic p;
      if ($urandom_range(0, 49) == 0) curTmo = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) curEn = 6'($urandom);
      if ($urandom_range(0, 19) == 0) curGate = ~curGate;
      p = ($urandom_range(0, 399) == 0);
      if (busLeft > 0) begin
        b = 1'b1;
        busLeft--;
      end else if (gapLeft > 0) begin
        b = 1'b0;
        gapLeft--;
      end else begin
        b       = 1'b1;
        busLeft = $urandom_range(0, 7);
        gapLeft = $urandom_range(1, 70);
        curCs   = 6'(1 << $urandom_range(0, 5));
        if ($urandom_range(0, 3) == 0) curCs = 6'($urandom);
      end
      applyStimulus(p, b, curCs, curEn, curTmo, curGate);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
